// File: rtl/tick_gen.sv
// tick_gen: runtime-programmable tick generator (common timebase source).
// Counts enabled clk cycles and pulses tick every div+1 cycles, with
// periodic / one-shot modes, start/stop/clear control and a shadowed
// divisor that is only committed at period boundaries while running.
// Optional feature: define TICK_GEN_PHASE_EN to build the phase_out
// square-wave toggle flop; otherwise phase_out is tied low.
module tick_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 20
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             oneshot,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             phase_out
);

  localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  logic [WIDTH-1:0] countQ;
  logic [WIDTH-1:0] divActive;
  logic [WIDTH-1:0] divShadow;
  logic             loadPending;
  logic             oneshotMode;
  logic             tickNow;

  // Terminal count is decoded purely from registers, only while running.
  assign tickNow = (state == RUN) && (countQ == divActive);

  assign tick  = tickNow;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign count = countQ;

  // Control FSM, counter and divisor/shadow bookkeeping.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      countQ      <= '0;
      divActive   <= ResetDiv;
      divShadow   <= '0;
      loadPending <= 1'b0;
      oneshotMode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_load) begin
            divActive <= div_in;
          end
          loadPending <= 1'b0;
          if (stop) begin
            state <= IDLE;
          end else if (clear) begin
            countQ <= '0;
          end else if (start) begin
            state       <= RUN;
            countQ      <= '0;
            oneshotMode <= oneshot;
          end
        end

        RUN: begin
          // Period boundary or leaving RUN commits the newest divisor value.
          if (stop || tickNow) begin
            if (div_load) begin
              divActive <= div_in;
            end else if (loadPending) begin
              divActive <= divShadow;
            end
            loadPending <= 1'b0;
          end else if (div_load) begin
            divShadow   <= div_in;
            loadPending <= 1'b1;
          end

          if (stop) begin
            state <= IDLE;
          end else if (clear) begin
            countQ <= '0;
          end else if (tickNow) begin
            countQ <= '0;
            if (oneshotMode) begin
              state <= DONE;
            end
          end else begin
            countQ <= countQ + WIDTH'(1);
          end
        end

        DONE: begin
          if (div_load) begin
            divActive <= div_in;
          end
          loadPending <= 1'b0;
          countQ      <= '0;
          if (stop || clear) begin
            state <= IDLE;
          end else if (start) begin
            state       <= RUN;
            oneshotMode <= oneshot;
          end
        end

        default: begin
          state       <= IDLE;
          countQ      <= '0;
          loadPending <= 1'b0;
        end
      endcase
    end
  end

`ifdef TICK_GEN_PHASE_EN
  logic phaseQ;

  // Square wave: toggles at each tick-cycle end; clear or stop-to-IDLE zeroes it.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      phaseQ <= 1'b0;
    end else if ((stop && (state != IDLE)) || clear) begin
      phaseQ <= 1'b0;
    end else if (tickNow) begin
      phaseQ <= ~phaseQ;
    end
  end

  assign phase_out = phaseQ;
`else
  assign phase_out = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: a per-cycle vector table checked through
// an expected-output queue, plus hand-written multi-cycle sequences.
module tb_tick_gen;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             nRST;
  logic             start;
  logic             stop;
  logic             clear;
  logic             oneshot;
  logic             div_load;
  logic [WIDTH-1:0] div_in;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic             phase_out;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic       oneshot;
    logic       divLoad;
    logic [7:0] divIn;
    logic       expTick;
    logic       expBusy;
    logic       expDone;
    logic [7:0] expCount;
  } vecT;

  typedef struct packed {
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] count;
  } outT;

  vecT vecs[$];
  outT expQ[$];

  tick_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(20)) dut (
    .clk(clk),
    .nRST(nRST),
    .start(start),
    .stop(stop),
    .clear(clear),
    .oneshot(oneshot),
    .div_load(div_load),
    .div_in(div_in),
    .tick(tick),
    .busy(busy),
    .done(done),
    .count(count),
    .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idleIn();
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
    oneshot  = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until tick is seen (bounded); n = edges taken.
  task automatic waitTick(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic addVec(input logic s, input logic p, input logic c, input logic o,
                        input logic dl, input logic [7:0] di, input logic et,
                        input logic eb, input logic ed, input logic [7:0] ec);
    vecT v;
    v.start = s; v.stop = p; v.clear = c; v.oneshot = o; v.divLoad = dl; v.divIn = di;
    v.expTick = et; v.expBusy = eb; v.expDone = ed; v.expCount = ec;
    vecs.push_back(v);
  endtask

  initial begin
    int  n;
    int  ticks;
    logic expPh;
    outT got;
    outT e;

    idleIn();
    nRST = 1'b1;

    // start stop clr osh dl din | tick busy done count
    addVec(0, 0, 0, 0, 1, 2,   0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(0, 1, 0, 0, 0, 0,   0, 0, 0, 1);
    addVec(1, 0, 0, 1, 0, 0,   0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    addVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    addVec(1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(0, 0, 1, 0, 0, 0,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(1, 1, 0, 0, 0, 0,   0, 0, 0, 1);
    addVec(0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 0,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    addVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    addVec(0, 0, 1, 0, 0, 0,   0, 0, 0, 0);

    // Reset state
    #2 nRST = 1'b0;
    #1;
    chk("reset_tick", 32'(tick), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_phase", 32'(phase_out), 0);
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;

    // Default divisor, periodic
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("def_busy", 32'(busy), 1);
    chk("def_done", 32'(done), 0);
    chk("def_count0", 32'(count), 0);
    waitTick(60, n);
    chk("def_latency", 32'(n + 1), 21);
    waitTick(60, n);
    chk("def_period1", 32'(n), 21);
    waitTick(60, n);
    chk("def_period2", 32'(n), 21);
    chk("def_busy_run", 32'(busy), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    // Table vectors through the expected queue
    foreach (vecs[i]) begin
      start    = vecs[i].start;
      stop     = vecs[i].stop;
      clear    = vecs[i].clear;
      oneshot  = vecs[i].oneshot;
      div_load = vecs[i].divLoad;
      div_in   = vecs[i].divIn;
      expQ.push_back('{tick: vecs[i].expTick, busy: vecs[i].expBusy,
                       done: vecs[i].expDone, count: vecs[i].expCount});
      cyc();
      got = '{tick: tick, busy: busy, done: done, count: count};
      e = expQ.pop_front();
      nChecks++;
      if (got !== e) begin
        nFails++;
        $display("FAIL vec%0d: got tick=%0d busy=%0d done=%0d count=%0d, expected tick=%0d busy=%0d done=%0d count=%0d",
                 i, got.tick, got.busy, got.done, got.count, e.tick, e.busy, e.done, e.count);
      end
    end
    idleIn();

    // One-shot with divisor 5
    div_load = 1'b1;
    div_in = 8'd5;
    cyc();
    idleIn();
    start = 1'b1;
    oneshot = 1'b1;
    cyc();
    idleIn();
    waitTick(30, n);
    chk("os_latency", 32'(n + 1), 6);
    cyc();
    chk("os_done", 32'(done), 1);
    chk("os_busy", 32'(busy), 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick) ticks++;
    end
    chk("os_no_more_ticks", 32'(ticks), 0);
    chk("os_done_held", 32'(done), 1);

    // Shadowed divisor change mid-period
    div_load = 1'b1;
    div_in = 8'd10;
    cyc();
    idleIn();
    start = 1'b1;
    cyc();
    idleIn();
    for (int i = 0; i < 4; i++) cyc();
    chk("sh_count4", 32'(count), 4);
    div_load = 1'b1;
    div_in = 8'd3;
    cyc();
    idleIn();
    chk("sh_count5", 32'(count), 5);
    waitTick(30, n);
    chk("sh_old_period_end", 32'(n), 5);
    chk("sh_tick_count10", 32'(count), 10);
    waitTick(30, n);
    chk("sh_new_period1", 32'(n), 4);
    chk("sh_tick_count3", 32'(count), 3);
    waitTick(30, n);
    chk("sh_new_period2", 32'(n), 4);

    // stop and clear together: stop wins
    stop = 1'b1;
    cyc();
    idleIn();
    div_load = 1'b1;
    div_in = 8'd10;
    cyc();
    idleIn();
    start = 1'b1;
    cyc();
    idleIn();
    for (int i = 0; i < 7; i++) cyc();
    chk("sc_count7", 32'(count), 7);
    stop = 1'b1;
    clear = 1'b1;
    cyc();
    idleIn();
    chk("sc_busy", 32'(busy), 0);
    chk("sc_count_held", 32'(count), 7);
    clear = 1'b1;
    cyc();
    idleIn();
    chk("sc_clear_count", 32'(count), 0);
    chk("sc_clear_busy", 32'(busy), 0);

    // Divisor 0: tick every RUN cycle, phase toggles each cycle when built
    div_load = 1'b1;
    div_in = 8'd0;
    cyc();
    idleIn();
    start = 1'b1;
    cyc();
    idleIn();
    chk("d0_tick_first", 32'(tick), 1);
    chk("d0_busy", 32'(busy), 1);
    expPh = 1'b0;
    chk("d0_phase_first", 32'(phase_out), 32'(expPh));
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("d0_tick%0d", i), 32'(tick), 1);
`ifdef TICK_GEN_PHASE_EN
      expPh = ~expPh;
`endif
      chk($sformatf("d0_phase%0d", i), 32'(phase_out), 32'(expPh));
    end
    stop = 1'b1;
    cyc();
    idleIn();
    chk("d0_stop_busy", 32'(busy), 0);
    chk("d0_stop_phase", 32'(phase_out), 0);
    start = 1'b1;
    oneshot = 1'b1;
    cyc();
    idleIn();
    chk("d0_os_tick", 32'(tick), 1);
    cyc();
    chk("d0_os_done", 32'(done), 1);
    chk("d0_os_tick_off", 32'(tick), 0);

    // Async reset mid-period with a pending load
    clear = 1'b1;
    cyc();
    idleIn();
    div_load = 1'b1;
    div_in = 8'd10;
    cyc();
    idleIn();
    start = 1'b1;
    cyc();
    idleIn();
    for (int i = 0; i < 3; i++) cyc();
    div_load = 1'b1;
    div_in = 8'd4;
    cyc();
    idleIn();
    cyc();
    cyc();
    chk("rst_pre_count", 32'(count), 6);
    #3 nRST = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_count", 32'(count), 0);
    chk("rst_async_tick", 32'(tick), 0);
    chk("rst_async_done", 32'(done), 0);
    chk("rst_async_phase", 32'(phase_out), 0);
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    start = 1'b1;
    cyc();
    idleIn();
    waitTick(60, n);
    chk("rst_latency", 32'(n + 1), 21);
    waitTick(60, n);
    chk("rst_period", 32'(n), 21);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
